// File: rtl/param_register_file_if.sv
// Decode/writeback bus for param_register_file: two read ports with busy flags,
// one write port and one reserve port.
interface param_register_file_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] selA;
  logic [ADDR_W-1:0] selB;
  logic [WIDTH-1:0]  outA;
  logic [WIDTH-1:0]  outB;
  logic              busyA;
  logic              busyB;
  logic              writeEnable;
  logic [ADDR_W-1:0] selWrite;
  logic [WIDTH-1:0]  writeIn;
  logic              reserveEnable;
  logic [ADDR_W-1:0] selReserve;

  modport master (
    output selA, selB, writeEnable, selWrite, writeIn, reserveEnable, selReserve,
    input  outA, outB, busyA, busyB
  );

  modport slave (
    input  selA, selB, writeEnable, selWrite, writeIn, reserveEnable, selReserve,
    output outA, outB, busyA, busyB
  );
endinterface

// File: rtl/param_register_file.sv
// Register file with two combinational read ports, write-to-read bypass, an
// optional hardwired zero register and a per-register busy scoreboard.
module param_register_file #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rstN,
  param_register_file_if.slave  io_bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_rsv_hit;
  logic [WIDTH-1:0] w_outA;
  logic [WIDTH-1:0] w_outB;
  logic             w_busyA;
  logic             w_busyB;

  // One-hot per-register enables; out-of-range and zero-register indices never match.
  always_comb begin
    w_wr_hit  = '0;
    w_rsv_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        w_wr_hit[i]  = io_bus.writeEnable   && (io_bus.selWrite   == ADDR_W'(i));
        w_rsv_hit[i] = io_bus.reserveEnable && (io_bus.selReserve == ADDR_W'(i));
      end
    end
  end

  // A retiring write satisfies a pending hazard in the same cycle via bypass.
  always_comb begin
    w_outA  = '0;
    w_outB  = '0;
    w_busyA = 1'b0;
    w_busyB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (io_bus.selA == ADDR_W'(i)) begin
        w_outA  = w_wr_hit[i] ? io_bus.writeIn : r_regs[i];
        w_busyA = r_busy[i] && !w_wr_hit[i];
      end
      if (io_bus.selB == ADDR_W'(i)) begin
        w_outB  = w_wr_hit[i] ? io_bus.writeIn : r_regs[i];
        w_busyB = r_busy[i] && !w_wr_hit[i];
      end
    end
  end

  assign io_bus.outA  = w_outA;
  assign io_bus.outB  = w_outB;
  assign io_bus.busyA = w_busyA;
  assign io_bus.busyB = w_busyB;

  // A reserve on the same edge as a write to that register keeps it busy.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_hit[i]) begin
          r_regs[i] <= io_bus.writeIn;
        end
        if (w_rsv_hit[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_hit[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed vector table on a DEPTH=4 instance,
// hand sequences for reset and the zero register, then random traffic vs a model.
module tb_param_register_file;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  param_register_file_if #(.WIDTH(64), .DEPTH(4)) bus0 ();
  param_register_file_if #(.WIDTH(64), .DEPTH(5)) bus1 ();

  param_register_file #(.WIDTH(64), .DEPTH(4), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rstN(rstN), .io_bus(bus0)
  );
  param_register_file #(.WIDTH(64), .DEPTH(5), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rstN(rstN), .io_bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  ws;
    logic [63:0] wd;
    logic        re;
    logic [1:0]  rs;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        eba;
    logic        ebb;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] ws, logic [63:0] wd, logic re,
                              logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                              logic [63:0] ea, logic [63:0] eb, logic eba, logic ebb);
    vec_t v;
    v.we = we; v.ws = ws; v.wd = wd; v.re = re; v.rs = rs;
    v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic drive0(logic we, logic [1:0] ws, logic [63:0] wd, logic re,
                        logic [1:0] rs, logic [1:0] sa, logic [1:0] sb);
    bus0.writeEnable = we; bus0.selWrite = ws; bus0.writeIn = wd;
    bus0.reserveEnable = re; bus0.selReserve = rs; bus0.selA = sa; bus0.selB = sb;
  endtask

  task automatic drive1(logic we, logic [2:0] ws, logic [63:0] wd, logic re,
                        logic [2:0] rs, logic [2:0] sa, logic [2:0] sb);
    bus1.writeEnable = we; bus1.selWrite = ws; bus1.writeIn = wd;
    bus1.reserveEnable = re; bus1.selReserve = rs; bus1.selA = sa; bus1.selB = sb;
  endtask

  // Reference model: plain arrays indexed by instance (0: DEPTH 4, 1: DEPTH 5 + zero reg).
  logic [63:0] m_reg  [2][8];
  logic        m_busy [2][8];
  int          m_depth [2] = '{4, 5};
  int          m_zero  [2] = '{0, 1};

  function automatic bit m_writable(int d, int i);
    return (i < m_depth[d]) && !(m_zero[d] != 0 && i == 0);
  endfunction

  function automatic logic [63:0] m_out(int d, int sel, bit we, int ws, logic [63:0] wd);
    if (we && ws == sel && m_writable(d, sel)) return wd;
    if (sel < m_depth[d]) return m_reg[d][sel];
    return 64'd0;
  endfunction

  function automatic logic m_bsy(int d, int sel, bit we, int ws);
    if (we && ws == sel && m_writable(d, sel)) return 1'b0;
    if (sel < m_depth[d]) return m_busy[d][sel];
    return 1'b0;
  endfunction

  task automatic m_edge(int d, bit we, int ws, logic [63:0] wd, bit re, int rs);
    if (we && m_writable(d, ws)) begin
      m_reg[d][ws]  = wd;
      m_busy[d][ws] = 1'b0;
    end
    if (re && m_writable(d, rs)) m_busy[d][rs] = 1'b1;
  endtask

  task automatic m_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        m_reg[d][i]  = 64'd0;
        m_busy[d][i] = 1'b0;
      end
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1, 2, 64'hDEAD_BEEF_0123_4567, 0, 0, 2, 1, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 0);
    tbl[1]  = mk(0, 0, 64'h0, 0, 0, 2, 1, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 0);
    tbl[2]  = mk(1, 3, 64'h55, 0, 0, 3, 3, 64'h55, 64'h55, 0, 0);
    tbl[3]  = mk(0, 0, 64'h0, 0, 0, 3, 2, 64'h55, 64'hDEAD_BEEF_0123_4567, 0, 0);
    tbl[4]  = mk(0, 0, 64'h0, 1, 1, 1, 0, 64'h0, 64'h0, 0, 0);
    tbl[5]  = mk(0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 64'h0, 1, 0);
    tbl[6]  = mk(1, 1, 64'h7, 0, 0, 1, 1, 64'h7, 64'h7, 0, 0);
    tbl[7]  = mk(0, 0, 64'h0, 0, 0, 1, 0, 64'h7, 64'h0, 0, 0);
    tbl[8]  = mk(1, 2, 64'h9, 1, 2, 2, 2, 64'h9, 64'h9, 0, 0);
    tbl[9]  = mk(0, 0, 64'h0, 0, 0, 2, 3, 64'h9, 64'h55, 1, 0);
    tbl[10] = mk(0, 0, 64'h0, 1, 0, 0, 2, 64'h0, 64'h9, 0, 1);
    tbl[11] = mk(1, 2, 64'hAB, 1, 3, 0, 2, 64'h0, 64'hAB, 1, 0);
    tbl[12] = mk(0, 0, 64'h0, 0, 0, 3, 2, 64'h55, 64'hAB, 1, 0);

    drive0(0, 0, 64'h0, 0, 0, 0, 0);
    drive1(0, 0, 64'h0, 0, 0, 0, 0);
    rstN = 1'b0;
    #12;
    chk64("rst_outA0", bus0.outA, 64'h0);
    chk64("rst_outB0", bus0.outB, 64'h0);
    chk1("rst_busyA0", bus0.busyA, 1'b0);
    chk64("rst_outA1", bus1.outA, 64'h0);
    rstN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      drive0(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].re, tbl[i].rs, tbl[i].sa, tbl[i].sb);
      #1;
      chk64($sformatf("vec%0d_outA", i), bus0.outA, tbl[i].ea);
      chk64($sformatf("vec%0d_outB", i), bus0.outB, tbl[i].eb);
      chk1($sformatf("vec%0d_busyA", i), bus0.busyA, tbl[i].eba);
      chk1($sformatf("vec%0d_busyB", i), bus0.busyB, tbl[i].ebb);
      @(posedge clk); #1;
    end

    // Async reset mid-cycle while a write is pending: state clears at once, write lost.
    drive0(1, 1, 64'hFFFF_0000_1111_2222, 0, 0, 2, 3);
    #3 rstN = 1'b0;
    #1;
    chk64("midrst_outA", bus0.outA, 64'h0);
    chk64("midrst_outB", bus0.outB, 64'h0);
    chk1("midrst_busyB", bus0.busyB, 1'b0);
    @(posedge clk); #2;
    rstN = 1'b1;
    drive0(0, 0, 64'h0, 0, 0, 1, 3);
    #1;
    chk64("postrst_outA_r1", bus0.outA, 64'h0);
    chk1("postrst_busyB_r3", bus0.busyB, 1'b0);
    @(posedge clk); #1;
    chk64("postrst_outA_r1_edge", bus0.outA, 64'h0);

    // Zero register and out-of-range indices on the DEPTH=5 instance.
    drive1(1, 0, 64'hFF, 1, 0, 0, 4);
    #1;
    chk64("z_bypass_outA", bus1.outA, 64'h0);
    chk1("z_bypass_busyA", bus1.busyA, 1'b0);
    @(posedge clk); #1;
    drive1(1, 4, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 4);
    #1;
    chk64("z_outA_r0", bus1.outA, 64'h0);
    chk1("z_busyA_r0", bus1.busyA, 1'b0);
    chk64("z_outB_r4_bypass", bus1.outB, 64'hCAFE_F00D_0000_0001);
    @(posedge clk); #1;
    drive1(1, 6, 64'h1, 1, 7, 7, 4);
    #1;
    chk64("z_outA_r7", bus1.outA, 64'h0);
    chk1("z_busyA_r7", bus1.busyA, 1'b0);
    chk64("z_outB_r4", bus1.outB, 64'hCAFE_F00D_0000_0001);
    @(posedge clk); #1;
    drive1(0, 0, 64'h0, 0, 0, 6, 7);
    #1;
    chk64("z_outA_r6", bus1.outA, 64'h0);
    chk1("z_busyB_r7", bus1.busyB, 1'b0);

    // Random traffic on both instances against the model.
    rstN = 1'b0;
    #2 rstN = 1'b1;
    m_clear();
    @(posedge clk); #1;
    for (int n = 0; n < 600; n++) begin
      bit          we0, re0, we1, re1;
      int          ws0, rs0, sa0, sb0, ws1, rs1, sa1, sb1;
      logic [63:0] wd0, wd1;
      we0 = ($urandom_range(0, 1) == 1); re0 = ($urandom_range(0, 2) == 0);
      ws0 = $urandom_range(0, 3); rs0 = $urandom_range(0, 3);
      sa0 = $urandom_range(0, 3); sb0 = $urandom_range(0, 3);
      wd0 = {$urandom(), $urandom()};
      we1 = ($urandom_range(0, 1) == 1); re1 = ($urandom_range(0, 2) == 0);
      ws1 = $urandom_range(0, 7); rs1 = $urandom_range(0, 7);
      sa1 = $urandom_range(0, 7); sb1 = $urandom_range(0, 7);
      wd1 = {$urandom(), $urandom()};
      drive0(we0, 2'(ws0), wd0, re0, 2'(rs0), 2'(sa0), 2'(sb0));
      drive1(we1, 3'(ws1), wd1, re1, 3'(rs1), 3'(sa1), 3'(sb1));
      #1;
      chk64("rnd0_outA", bus0.outA, m_out(0, sa0, we0, ws0, wd0));
      chk64("rnd0_outB", bus0.outB, m_out(0, sb0, we0, ws0, wd0));
      chk1("rnd0_busyA", bus0.busyA, m_bsy(0, sa0, we0, ws0));
      chk1("rnd0_busyB", bus0.busyB, m_bsy(0, sb0, we0, ws0));
      chk64("rnd1_outA", bus1.outA, m_out(1, sa1, we1, ws1, wd1));
      chk64("rnd1_outB", bus1.outB, m_out(1, sb1, we1, ws1, wd1));
      chk1("rnd1_busyA", bus1.busyA, m_bsy(1, sa1, we1, ws1));
      chk1("rnd1_busyB", bus1.busyB, m_bsy(1, sb1, we1, ws1));
      @(posedge clk); #1;
      m_edge(0, we0, ws0, wd0, re0, rs0);
      m_edge(1, we1, ws1, wd1, re1, rs1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
